ghost_mode_ctrl: RTL and testbench

Consumes the frightened-timer outputs (eat_time, white) and produces each ghost's behaviour mode for the ghost AI and sprite renderer. Owns the global scatter/chase schedule, which pauses while frightened. Owns per-ghost FRIGHT/EATEN tracking, ghost-eat score combos and Pac-Man death detection. Sits between the frightened timer and the ghost movement and render logic.

---
 rtl/ghost_pkg.sv | 34 +++
 rtl/ghost_phase_timer.sv | 59 +++++
 rtl/ghost_mode_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ghost_mode_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ghost_pkg : shared types and constants for the ghost mode controller  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ghost_pkg;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'b00,
        MODE_CHASE   = 2'b01,
        MODE_FRIGHT  = 2'b10,
        MODE_EATEN   = 2'b11
    } ghost_mode_t;

    typedef enum logic [1:0] {
        GST_NORMAL = 2'd0,
        GST_FRIGHT = 2'd1,
        GST_EATEN  = 2'd2
    } ghost_st_t;

    typedef enum logic [1:0] {
        TOP_IDLE  = 2'd0,
        TOP_PLAY  = 2'd1,
        TOP_DYING = 2'd2
    } top_st_t;

    // Phases 0..6 in seconds; phase 7 is open-ended and has no entry.
    localparam int unsigned c_phase_sec [7] = '{7, 20, 7, 20, 5, 20, 5};

    localparam logic [11:0] SCORE_BASE = 12'd200;

endpackage

`default_nettype wire

// File: rtl/ghost_phase_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ghost_phase_timer : scatter/chase schedule with pause and restart     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ghost_phase_timer
    import ghost_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        level_init,
    input  logic        run,
    input  logic        pause,
    output ghost_mode_t sched_mode,
    output logic        phase_chg
);

    logic [2:0]  r_phase;
    logic [31:0] r_timer;
    logic [31:0] w_limit;
    logic        w_wrap;
    logic [2:0]  w_phase_nxt;

    always_comb begin
        w_limit = '0;
        for (int i = 0; i < 7; i++) begin
            if (r_phase == 3'(i)) begin
                w_limit = c_phase_sec[i] * CLK_HZ - 32'd1;
            end
        end
    end

    assign w_wrap      = run && !pause && !level_init && (r_phase != 3'd7) && (r_timer == w_limit);
    assign w_phase_nxt = level_init ? 3'd0 : (w_wrap ? r_phase + 3'd1 : r_phase);

    // Mode of the phase that will be current after this edge, so the
    // registered ghost modes change on the same edge as the phase.
    assign sched_mode = w_phase_nxt[0] ? MODE_CHASE : MODE_SCATTER;
    assign phase_chg  = w_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= 3'd0;
            r_timer <= 32'd0;
        end else begin
            r_phase <= w_phase_nxt;
            if (level_init) begin
                r_timer <= 32'd0;
            end else if (run && !pause) begin
                r_timer <= w_wrap ? 32'd0 : r_timer + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ghost_mode_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ghost_mode_ctrl : per-ghost mode, eat combos and death detection      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ghost_mode_ctrl
    import ghost_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int          NUM_GHOSTS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    level_start,
    input  logic                    eat_time,
    input  logic                    white,
    input  logic [NUM_GHOSTS-1:0]   ghost_hit,
    input  logic [NUM_GHOSTS-1:0]   ghost_home,
    output logic [2*NUM_GHOSTS-1:0] ghost_mode,
    output logic [NUM_GHOSTS-1:0]   ghost_white,
    output logic                    reverse_dir,
    output logic [11:0]             score_add,
    output logic                    score_vld,
    output logic                    pacman_die
);

    top_st_t     r_top, w_top_nxt;
    ghost_st_t   r_st     [NUM_GHOSTS];
    ghost_st_t   w_post   [NUM_GHOSTS];
    ghost_st_t   w_st_nxt [NUM_GHOSTS];
    logic [1:0]  r_combo, w_combo_nxt, w_combo_cur;
    logic        r_eat_d;
    logic        w_rise, w_fall, w_taken, w_normal_hit;
    ghost_mode_t w_sched;
    logic        w_phase_chg;

    logic [2*NUM_GHOSTS-1:0] r_ghost_mode, w_mode_nxt;
    logic [NUM_GHOSTS-1:0]   r_ghost_white, w_white_nxt;
    logic                    r_reverse_dir, w_rev_nxt;
    logic [11:0]             r_score_add, w_score_nxt;
    logic                    r_score_vld, w_vld_nxt;
    logic                    r_pacman_die, w_die_nxt;

    ghost_phase_timer #(.CLK_HZ(CLK_HZ)) u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .level_init (level_start),
        .run        (r_top == TOP_PLAY),
        .pause      (eat_time),
        .sched_mode (w_sched),
        .phase_chg  (w_phase_chg)
    );

    assign w_rise = eat_time && !r_eat_d;
    assign w_fall = !eat_time && r_eat_d;

    always_comb begin
        w_top_nxt    = r_top;
        w_post       = r_st;
        w_st_nxt     = r_st;
        w_combo_cur  = r_combo;
        w_combo_nxt  = r_combo;
        w_mode_nxt   = r_ghost_mode;
        w_white_nxt  = r_ghost_white;
        w_rev_nxt    = 1'b0;
        w_score_nxt  = '0;
        w_vld_nxt    = 1'b0;
        w_die_nxt    = 1'b0;
        w_taken      = 1'b0;
        w_normal_hit = 1'b0;

        if (level_start) begin
            w_top_nxt   = TOP_PLAY;
            for (int i = 0; i < NUM_GHOSTS; i++) w_st_nxt[i] = GST_NORMAL;
            w_combo_nxt = 2'd0;
            w_mode_nxt  = '0;
            w_white_nxt = '0;
        end else begin
            case (r_top)
                TOP_PLAY: begin
                    // Frightened edges first; hits see the post-edge state.
                    for (int i = 0; i < NUM_GHOSTS; i++) begin
                        if (w_rise && r_st[i] == GST_NORMAL)      w_post[i] = GST_FRIGHT;
                        else if (w_fall && r_st[i] == GST_FRIGHT) w_post[i] = GST_NORMAL;
                    end
                    if (w_rise) w_combo_cur = 2'd0;
                    w_combo_nxt = w_combo_cur;
                    w_st_nxt    = w_post;

                    for (int i = 0; i < NUM_GHOSTS; i++) begin
                        if (w_post[i] == GST_EATEN && ghost_home[i]) w_st_nxt[i] = GST_NORMAL;
                    end
                    for (int i = 0; i < NUM_GHOSTS; i++) begin
                        if (!w_taken && ghost_hit[i] && w_post[i] == GST_FRIGHT) begin
                            w_st_nxt[i] = GST_EATEN;
                            w_taken     = 1'b1;
                        end
                        if (ghost_hit[i] && w_post[i] == GST_NORMAL) w_normal_hit = 1'b1;
                    end

                    if (w_taken) begin
                        w_vld_nxt   = 1'b1;
                        w_score_nxt = SCORE_BASE << w_combo_cur;
                        if (w_combo_cur != 2'd3) w_combo_nxt = w_combo_cur + 2'd1;
                    end else if (w_normal_hit) begin
                        w_die_nxt = 1'b1;
                        w_top_nxt = TOP_DYING;
                    end

                    w_rev_nxt = w_phase_chg || w_rise;

                    for (int i = 0; i < NUM_GHOSTS; i++) begin
                        case (w_st_nxt[i])
                            GST_NORMAL: w_mode_nxt[2*i +: 2] = w_sched;
                            GST_FRIGHT: w_mode_nxt[2*i +: 2] = MODE_FRIGHT;
                            default:    w_mode_nxt[2*i +: 2] = MODE_EATEN;
                        endcase
                        w_white_nxt[i] = white && (w_st_nxt[i] == GST_FRIGHT);
                    end
                end
                TOP_DYING: begin
                    for (int i = 0; i < NUM_GHOSTS; i++) begin
                        w_white_nxt[i] = white && (r_st[i] == GST_FRIGHT);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_top         <= TOP_IDLE;
            for (int i = 0; i < NUM_GHOSTS; i++) r_st[i] <= GST_NORMAL;
            r_combo       <= 2'd0;
            r_eat_d       <= 1'b0;
            r_ghost_mode  <= '0;
            r_ghost_white <= '0;
            r_reverse_dir <= 1'b0;
            r_score_add   <= '0;
            r_score_vld   <= 1'b0;
            r_pacman_die  <= 1'b0;
        end else begin
            r_top         <= w_top_nxt;
            r_st          <= w_st_nxt;
            r_combo       <= w_combo_nxt;
            r_eat_d       <= eat_time;
            r_ghost_mode  <= w_mode_nxt;
            r_ghost_white <= w_white_nxt;
            r_reverse_dir <= w_rev_nxt;
            r_score_add   <= w_score_nxt;
            r_score_vld   <= w_vld_nxt;
            r_pacman_die  <= w_die_nxt;
        end
    end

    assign ghost_mode  = r_ghost_mode;
    assign ghost_white = r_ghost_white;
    assign reverse_dir = r_reverse_dir;
    assign score_add   = r_score_add;
    assign score_vld   = r_score_vld;
    assign pacman_die  = r_pacman_die;

endmodule

`default_nettype wire

// File: tb/tb_ghost_mode_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ghost_mode_ctrl : model-checked bench for ghost_mode_ctrl          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ghost_mode_ctrl;

    localparam int CLK = 10;
    localparam int NG  = 4;
    // Cumulative phase boundaries in seconds.
    localparam int CUM [7] = '{7, 27, 34, 54, 59, 79, 84};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          level_start = 1'b0;
    logic          eat_time = 1'b0;
    logic          white = 1'b0;
    logic [NG-1:0] ghost_hit = '0;
    logic [NG-1:0] ghost_home = '0;
    logic [2*NG-1:0] ghost_mode;
    logic [NG-1:0] ghost_white;
    logic          reverse_dir;
    logic [11:0]   score_add;
    logic          score_vld;
    logic          pacman_die;

    ghost_mode_ctrl #(.CLK_HZ(CLK), .NUM_GHOSTS(NG)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .level_start (level_start),
        .eat_time    (eat_time),
        .white       (white),
        .ghost_hit   (ghost_hit),
        .ghost_home  (ghost_home),
        .ghost_mode  (ghost_mode),
        .ghost_white (ghost_white),
        .reverse_dir (reverse_dir),
        .score_add   (score_add),
        .score_vld   (score_vld),
        .pacman_die  (pacman_die)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0    = 0;
    int n_rev = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        if (reverse_dir) n_rev++;
    end

    // ---------------- behavioural model ----------------
    // Ghost states: 0 normal, 1 frightened, 2 eaten. Top: 0 idle, 1 play, 2 dying.
    int          m_st [NG];
    int          m_top, m_cnt, m_combo, m_eaten, m_old;
    bit          m_eat_d, m_rise, m_fall, m_chg, m_die;
    logic [2*NG-1:0] e_mode;
    logic [NG-1:0]   e_white;
    bit          e_rev, e_vld, e_die;
    logic [11:0] e_score;

    function automatic int phase_of(input int c);
        int p = 0;
        for (int k = 0; k < 7; k++) if (c >= CUM[k] * CLK) p++;
        return p;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_top = 0; m_cnt = 0; m_combo = 0; m_eat_d = 0;
            for (int g = 0; g < NG; g++) m_st[g] = 0;
            e_mode = '0; e_white = '0; e_rev = 0; e_vld = 0; e_die = 0; e_score = '0;
        end else begin
            m_rise  = eat_time && !m_eat_d;
            m_fall  = !eat_time && m_eat_d;
            m_eat_d = eat_time;
            e_rev = 0; e_vld = 0; e_die = 0; e_score = '0;
            if (level_start) begin
                m_top = 1; m_cnt = 0; m_combo = 0;
                for (int g = 0; g < NG; g++) m_st[g] = 0;
                e_mode = '0; e_white = '0;
            end else if (m_top == 2) begin
                for (int g = 0; g < NG; g++) e_white[g] = white && (m_st[g] == 1);
            end else if (m_top == 1) begin
                m_chg = 0;
                if (!eat_time) begin
                    m_old = phase_of(m_cnt);
                    m_cnt++;
                    m_chg = (phase_of(m_cnt) != m_old);
                end
                for (int g = 0; g < NG; g++) begin
                    if (m_rise && m_st[g] == 0) m_st[g] = 1;
                    else if (m_fall && m_st[g] == 1) m_st[g] = 0;
                end
                if (m_rise) m_combo = 0;
                m_eaten = -1;
                m_die = 0;
                for (int g = NG - 1; g >= 0; g--) if (ghost_hit[g] && m_st[g] == 1) m_eaten = g;
                if (m_eaten < 0)
                    for (int g = 0; g < NG; g++) if (ghost_hit[g] && m_st[g] == 0) m_die = 1;
                for (int g = 0; g < NG; g++) if (m_st[g] == 2 && ghost_home[g]) m_st[g] = 0;
                if (m_eaten >= 0) begin
                    m_st[m_eaten] = 2;
                    e_vld   = 1;
                    e_score = 12'(200 * (1 << m_combo));
                    if (m_combo < 3) m_combo++;
                end else if (m_die) begin
                    e_die = 1;
                    m_top = 2;
                end
                e_rev = m_chg || m_rise;
                for (int g = 0; g < NG; g++) begin
                    e_mode[2*g +: 2] = (m_st[g] == 0) ? 2'(phase_of(m_cnt) % 2) :
                                       (m_st[g] == 1) ? 2'b10 : 2'b11;
                    e_white[g] = white && (m_st[g] == 1);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ghost_mode", 32'(ghost_mode), 32'(e_mode));
            chk("ghost_white", 32'(ghost_white), 32'(e_white));
            chk("reverse_dir", 32'(reverse_dir), 32'(e_rev));
            chk("score_vld", 32'(score_vld), 32'(e_vld));
            chk("pacman_die", 32'(pacman_die), 32'(e_die));
            if (e_vld) chk("score_add", 32'(score_add), 32'(e_score));
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_level();
        @(negedge clk);
        level_start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        level_start = 1'b0;
    endtask

    task automatic at_edge(input int k);
        while (cyc < t0 + k) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_mode", 32'(ghost_mode), 32'h0);
        chk("reset_pulses", {29'd0, reverse_dir, score_vld, pacman_die}, 32'h0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Schedule
        start_level();
        n_rev = 0;
        at_edge(69);  chk("sched_p0_end", 32'(ghost_mode), 32'h00);
        at_edge(70);  chk("sched_p1", 32'(ghost_mode), 32'h55);
                      chk("sched_rev1", 32'(reverse_dir), 32'h1);
        at_edge(270); chk("sched_p2", 32'(ghost_mode), 32'h00);
        at_edge(340); chk("sched_p3", 32'(ghost_mode), 32'h55);
        at_edge(900); chk("sched_p7", 32'(ghost_mode), 32'h55);
                      chk("sched_rev_count", 32'(n_rev), 32'd7);
        at_edge(1200); chk("sched_p7_hold", 32'(n_rev), 32'd7);

        // Pause
        start_level();
        n_rev = 0;
        at_edge(20);  eat_time = 1'b1;
        at_edge(21);  chk("pause_fright", 32'(ghost_mode), 32'hAA);
                      chk("pause_rev", 32'(reverse_dir), 32'h1);
        at_edge(50);  eat_time = 1'b0;
        at_edge(99);  chk("pause_p0_end", 32'(ghost_mode), 32'h00);
                      chk("pause_rev_count", 32'(n_rev), 32'd1);
        at_edge(100); chk("pause_p1", 32'(ghost_mode), 32'h55);

        // Combo
        at_edge(110); eat_time = 1'b1;
        at_edge(112); ghost_hit = 4'b0101;
        at_edge(113); chk("combo_200", 32'(score_add), 32'd200);
        at_edge(114); chk("combo_400", 32'(score_add), 32'd400);
                      ghost_hit = 4'b1000;
        at_edge(115); chk("combo_800", 32'(score_add), 32'd800);
                      chk("combo_modes", 32'(ghost_mode), 32'hFB);
                      ghost_hit = 4'b0000;
        at_edge(120); eat_time = 1'b0;
        at_edge(121); chk("combo_g1_back", 32'(ghost_mode), 32'hF7);

        // Eaten return
        at_edge(125); eat_time = 1'b1;
        at_edge(126); chk("eaten_stay", 32'(ghost_mode), 32'hFB);
        at_edge(127); ghost_home = 4'b0001;
        at_edge(128); chk("eaten_home", 32'(ghost_mode), 32'hF9);
                      ghost_home = 4'b0000;
        at_edge(130); ghost_hit = 4'b0010;
        at_edge(131); chk("combo_restart", 32'(score_add), 32'd200);
                      ghost_hit = 4'b0000;
        at_edge(135); eat_time = 1'b0;
        at_edge(140); ghost_home = 4'b1111;
        at_edge(142); ghost_home = 4'b0000;
                      chk("all_home", 32'(ghost_mode), 32'h55);

        // Death
        at_edge(150); ghost_hit = 4'b0001;
        at_edge(151); chk("die_pulse", 32'(pacman_die), 32'h1);
                      ghost_hit = 4'b0000;
        at_edge(152); n_rev = 0;
        at_edge(400); chk("dying_frozen", 32'(ghost_mode), 32'h55);
                      chk("dying_no_rev", 32'(n_rev), 32'd0);
        start_level();
        chk("restart_mode", 32'(ghost_mode), 32'h00);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            level_start = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 39) == 0) eat_time = ~eat_time;
            if ($urandom_range(0, 3) == 0) white = ~white;
            ghost_hit  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            ghost_home = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
        end
        @(negedge clk);
        level_start = 1'b0; eat_time = 1'b0; white = 1'b0;
        ghost_hit = '0; ghost_home = '0;

        // Async reset mid-fright
        start_level();
        at_edge(2);  eat_time = 1'b1; white = 1'b1;
        at_edge(6);  chk("pre_reset_white", 32'(ghost_white), 32'hF);
        #2 reset_n = 1'b0;
        #1 chk("async_mode", 32'(ghost_mode), 32'h0);
           chk("async_white", 32'(ghost_white), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_rev = 0;
        repeat (6) @(negedge clk);
        chk("post_reset_rev", 32'(n_rev), 32'd0);
        chk("post_reset_mode", 32'(ghost_mode), 32'h0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
